// File: rtl/lane_dispatch_ctrl.sv
// lane_dispatch_ctrl: steers an unstriped byte stream onto two PHY lanes.
// Lane choice alternates per word or per burst. A stalled byte waits for its
// own lane and is never redirected. Per-lane word counters and a
// completed-burst counter are kept for status.
module lane_dispatch_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic              enable,
  input  logic              mode,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pause_0,
  input  logic              pause_1,
  output logic              ready_out,
  output logic [DATA_W-1:0] data_out_0,
  output logic              valid_out_0,
  output logic [DATA_W-1:0] data_out_1,
  output logic              valid_out_1,
  output logic              lane_sel,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  count_0,
  output logic [CNT_W-1:0]  count_1,
  output logic [CNT_W-1:0]  burst_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BURST = 2'b01,
    STALL = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic               lane_sel_q, lane_sel_d;
  logic               mode_q, mode_d;
  // Set once the current burst has moved at least one byte; decides whether
  // a return to IDLE counts as a completed burst.
  logic               got_byte_q, got_byte_d;
  logic [DATA_W-1:0]  data_out_0_q, data_out_0_d;
  logic [DATA_W-1:0]  data_out_1_q, data_out_1_d;
  logic               valid_out_0_q, valid_out_0_d;
  logic               valid_out_1_q, valid_out_1_d;
  logic [CNT_W-1:0]   count_0_q, count_0_d;
  logic [CNT_W-1:0]   count_1_q, count_1_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               target_paused;
  logic               accept;
  logic               end_burst;

  // Only the pause of the currently targeted lane can hold off the source.
  assign target_paused = lane_sel_q ? pause_1 : pause_0;
  assign ready_out     = reset_L & enable & ~target_paused;
  assign accept        = valid_in & ready_out;

  // Next-state, lane steering, output staging and counter updates.
  always_comb begin
    state_d       = state_q;
    lane_sel_d    = lane_sel_q;
    mode_d        = mode_q;
    got_byte_d    = got_byte_q;
    count_0_d     = count_0_q;
    count_1_d     = count_1_q;
    burst_cnt_d   = burst_cnt_q;
    end_burst     = 1'b0;
    valid_out_0_d = accept & ~lane_sel_q;
    valid_out_1_d = accept & lane_sel_q;
    data_out_0_d  = valid_out_0_d ? data_in : '0;
    data_out_1_d  = valid_out_1_d ? data_in : '0;

    if (enable) begin
      // Mode is latched only between bursts so a burst never changes policy.
      if (state_q == IDLE) mode_d = mode;
      case (state_q)
        IDLE: begin
          if (accept)        state_d = BURST;
          else if (valid_in) state_d = STALL;
        end
        BURST: begin
          if (accept)        state_d = BURST;
          else if (valid_in) state_d = STALL;
          else               end_burst = 1'b1;
        end
        STALL: begin
          if (accept)         state_d = BURST;
          else if (!valid_in) end_burst = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (accept) begin
      got_byte_d = 1'b1;
      if (!mode_q) lane_sel_d = ~lane_sel_q;
      if (lane_sel_q) count_1_d = count_1_q + CNT_W'(1);
      else            count_0_d = count_0_q + CNT_W'(1);
    end

    // A withdrawal that moved no bytes is not a burst and does not flip lanes.
    if (end_burst) begin
      state_d    = IDLE;
      got_byte_d = 1'b0;
      if (got_byte_q) begin
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
        if (mode_q) lane_sel_d = ~lane_sel_q;
      end
    end
  end

  // State and output registers; reset clears everything, dropping any in-flight byte.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_q       <= IDLE;
      lane_sel_q    <= 1'b0;
      mode_q        <= 1'b0;
      got_byte_q    <= 1'b0;
      data_out_0_q  <= '0;
      data_out_1_q  <= '0;
      valid_out_0_q <= 1'b0;
      valid_out_1_q <= 1'b0;
      count_0_q     <= '0;
      count_1_q     <= '0;
      burst_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      lane_sel_q    <= lane_sel_d;
      mode_q        <= mode_d;
      got_byte_q    <= got_byte_d;
      data_out_0_q  <= data_out_0_d;
      data_out_1_q  <= data_out_1_d;
      valid_out_0_q <= valid_out_0_d;
      valid_out_1_q <= valid_out_1_d;
      count_0_q     <= count_0_d;
      count_1_q     <= count_1_d;
      burst_cnt_q   <= burst_cnt_d;
    end
  end

  assign state       = state_q;
  assign lane_sel    = lane_sel_q;
  assign data_out_0  = data_out_0_q;
  assign data_out_1  = data_out_1_q;
  assign valid_out_0 = valid_out_0_q;
  assign valid_out_1 = valid_out_1_q;
  assign count_0     = count_0_q;
  assign count_1     = count_1_q;
  assign burst_cnt   = burst_cnt_q;

endmodule

// File: tb/tb_lane_dispatch_ctrl.sv
// Scoreboard bench for lane_dispatch_ctrl: stimulus pushes expected lane bytes
// into per-lane queues, a negedge monitor pops and compares lane outputs.
module tb_lane_dispatch_ctrl;

  logic       clk_2f;
  logic       reset_L;
  logic       enable;
  logic       mode;
  logic       valid_in;
  logic [7:0] data_in;
  logic       pause_0;
  logic       pause_1;
  logic       ready_out;
  logic [7:0] data_out_0;
  logic       valid_out_0;
  logic [7:0] data_out_1;
  logic       valid_out_1;
  logic       lane_sel;
  logic [1:0] state;
  logic [7:0] count_0;
  logic [7:0] count_1;
  logic [7:0] burst_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp0;
  logic [7:0] exp1;

  lane_dispatch_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
    .clk_2f     (clk_2f),
    .reset_L    (reset_L),
    .enable     (enable),
    .mode       (mode),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .pause_0    (pause_0),
    .pause_1    (pause_1),
    .ready_out  (ready_out),
    .data_out_0 (data_out_0),
    .valid_out_0(valid_out_0),
    .data_out_1 (data_out_1),
    .valid_out_1(valid_out_1),
    .lane_sel   (lane_sel),
    .state      (state),
    .count_0    (count_0),
    .count_1    (count_1),
    .burst_cnt  (burst_cnt)
  );

  initial begin
    clk_2f = 1'b0;
    forever #5 clk_2f = ~clk_2f;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before limit");
    $fatal(1, "watchdog");
  end

  // Monitor: every lane valid must match the head of that lane's queue.
  always @(negedge clk_2f) begin
    checks++;
    if (valid_out_0) begin
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL lane0_unexpected: got %02h, required no output", data_out_0);
      end else begin
        exp0 = q0.pop_front();
        if (data_out_0 !== exp0) begin
          errors++;
          $display("FAIL lane0_data: got %02h, required %02h", data_out_0, exp0);
        end else $display("lane0 byte %02h ok", data_out_0);
      end
    end else if (data_out_0 !== 8'h00) begin
      errors++;
      $display("FAIL lane0_idle_data: got %02h, required 00", data_out_0);
    end
    checks++;
    if (valid_out_1) begin
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL lane1_unexpected: got %02h, required no output", data_out_1);
      end else begin
        exp1 = q1.pop_front();
        if (data_out_1 !== exp1) begin
          errors++;
          $display("FAIL lane1_data: got %02h, required %02h", data_out_1, exp1);
        end else $display("lane1 byte %02h ok", data_out_1);
      end
    end else if (data_out_1 !== 8'h00) begin
      errors++;
      $display("FAIL lane1_idle_data: got %02h, required 00", data_out_1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else $display("check %s = %0h ok", name, act);
  endtask

  task automatic step();
    @(posedge clk_2f);
    #1;
  endtask

  // lane: 0/1 = expected lane, -1 = byte not expected on any lane
  task automatic send(input logic [7:0] d, input int lane);
    valid_in = 1'b1;
    data_in  = d;
    if (lane == 0) q0.push_back(d);
    else if (lane == 1) q1.push_back(d);
    step();
  endtask

  task automatic idle_step();
    valid_in = 1'b0;
    data_in  = 8'h00;
    step();
  endtask

  task automatic chk_status(input string tag, input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] bc, input logic ls, input logic [1:0] st);
    chk({tag, "_count_0"}, 32'(count_0), 32'(c0));
    chk({tag, "_count_1"}, 32'(count_1), 32'(c1));
    chk({tag, "_burst_cnt"}, 32'(burst_cnt), 32'(bc));
    chk({tag, "_lane_sel"}, 32'(lane_sel), 32'(ls));
    chk({tag, "_state"}, 32'(state), 32'(st));
  endtask

  task automatic chk_drained(input string tag);
    step();
    chk({tag, "_q0_left"}, 32'(q0.size()), 32'd0);
    chk({tag, "_q1_left"}, 32'(q1.size()), 32'd0);
  endtask

  initial begin
    reset_L  = 1'b0;
    enable   = 1'b0;
    mode     = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    pause_0  = 1'b0;
    pause_1  = 1'b0;
    step();
    step();
    chk_status("reset", 8'd0, 8'd0, 8'd0, 1'b0, 2'd0);
    chk("reset_ready", 32'(ready_out), 32'd0);
    reset_L = 1'b1;
    enable  = 1'b1;
    step();

    // Word mode: alternate lanes every byte.
    mode = 1'b0;
    idle_step();
    #1 chk("word_ready", 32'(ready_out), 32'd1);
    send(8'hA1, 0);
    chk("word_state_burst", 32'(state), 32'd1);
    send(8'hA2, 1);
    send(8'hA3, 0);
    send(8'hA4, 1);
    idle_step();
    chk_status("word", 8'd2, 8'd2, 8'd1, 1'b0, 2'd0);
    chk_drained("word");

    // Burst mode: alternate lanes every burst.
    mode = 1'b1;
    idle_step();
    send(8'h10, 0);
    send(8'h11, 0);
    idle_step();
    chk_status("burst1", 8'd4, 8'd2, 8'd2, 1'b1, 2'd0);
    send(8'h20, 1);
    send(8'h21, 1);
    send(8'h22, 1);
    idle_step();
    chk_status("burst2", 8'd4, 8'd5, 8'd3, 1'b0, 2'd0);
    chk_drained("burst");

    // Both lanes paused: stall, then withdraw without any byte moved.
    pause_0  = 1'b1;
    pause_1  = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'hEE;
    #1 chk("bothpause_ready", 32'(ready_out), 32'd0);
    step();
    chk("bothpause_state", 32'(state), 32'd2);
    idle_step();
    chk_status("withdraw", 8'd4, 8'd5, 8'd3, 1'b0, 2'd0);
    pause_0 = 1'b0;
    pause_1 = 1'b0;

    // Backpressure on lane 1, with non-target pause ignored first.
    mode = 1'b0;
    idle_step();
    pause_1  = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h30;
    #1 chk("nontarget_pause_ready", 32'(ready_out), 32'd1);
    send(8'h30, 0);
    valid_in = 1'b1;
    data_in  = 8'h55;
    #1 chk("bp_ready", 32'(ready_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_state_stall", 32'(state), 32'd2);
      chk("bp_ready_stall", 32'(ready_out), 32'd0);
      chk("bp_lane_held", 32'(lane_sel), 32'd1);
    end
    pause_1 = 1'b0;
    #1 chk("bp_ready_release", 32'(ready_out), 32'd1);
    send(8'h55, 1);
    chk("bp_lane_toggled", 32'(lane_sel), 32'd0);
    chk("bp_state_burst", 32'(state), 32'd1);
    idle_step();
    chk_status("bp", 8'd5, 8'd6, 8'd4, 1'b0, 2'd0);
    chk_drained("bp");

    // Freeze mid-burst.
    send(8'h40, 0);
    enable   = 1'b0;
    valid_in = 1'b1;
    data_in  = 8'h41;
    #1 chk("freeze_ready", 32'(ready_out), 32'd0);
    step();
    step();
    chk_status("freeze", 8'd6, 8'd6, 8'd4, 1'b1, 2'd1);
    chk("freeze_valid0", 32'(valid_out_0), 32'd0);
    chk("freeze_valid1", 32'(valid_out_1), 32'd0);
    enable = 1'b1;
    send(8'h41, 1);
    idle_step();
    chk_status("unfreeze", 8'd6, 8'd7, 8'd5, 1'b0, 2'd0);
    chk_drained("freeze");

    // Mode change during a burst takes effect only after IDLE.
    send(8'h50, 0);
    mode = 1'b1;
    send(8'h51, 1);
    send(8'h52, 0);
    idle_step();
    chk_status("modeburst", 8'd8, 8'd8, 8'd6, 1'b1, 2'd0);
    idle_step();
    send(8'h60, 1);
    send(8'h61, 1);
    idle_step();
    chk_status("modeafter", 8'd8, 8'd10, 8'd7, 1'b0, 2'd0);
    chk_drained("mode");

    // Counter wrap: 256 accepts per lane bring both counters back around.
    mode = 1'b0;
    idle_step();
    for (int i = 0; i < 512; i++) send(8'(i), i % 2);
    idle_step();
    chk_status("wrap", 8'd8, 8'd10, 8'd8, 1'b0, 2'd0);
    chk_drained("wrap");

    // Reset mid-operation drops the in-flight byte.
    send(8'h70, -1);
    chk("inflight_valid0", 32'(valid_out_0), 32'd1);
    #1 reset_L = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("rst_valid0", 32'(valid_out_0), 32'd0);
    chk("rst_data0", 32'(data_out_0), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd0);
    chk_status("rst", 8'd0, 8'd0, 8'd0, 1'b0, 2'd0);
    step();
    reset_L = 1'b1;
    idle_step();
    send(8'h71, 0);
    idle_step();
    chk_status("postrst", 8'd1, 8'd0, 8'd1, 1'b1, 2'd0);
    chk_drained("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
